// File: rtl/gray_cnt_pkg.sv
// Shared definitions for the 2-bit Gray-code counter with init value.
// Holds the Gray-state constants, the next-state step function and the
// one-hot test-pattern select encodings used by the decoder.
package gray_cnt_pkg;

   // Gray-code states, listed in counting order 00 -> 01 -> 11 -> 10
   localparam logic [1:0] GC_00 = 2'b00;
   localparam logic [1:0] GC_01 = 2'b01;
   localparam logic [1:0] GC_11 = 2'b11;
   localparam logic [1:0] GC_10 = 2'b10;

   // Width of the one-hot test-pattern select (only 3 is supported)
   localparam int unsigned TP_SEL_W = 3;

   // One-hot test-pattern select encodings; GC_00 selects no pattern
   localparam logic [TP_SEL_W-1:0] SEL_NONE = 3'b000;
   localparam logic [TP_SEL_W-1:0] SEL_TP0  = 3'b001;
   localparam logic [TP_SEL_W-1:0] SEL_TP1  = 3'b010;
   localparam logic [TP_SEL_W-1:0] SEL_TP2  = 3'b100;

   // One Gray step; exactly one bit changes, 10 wraps to 00 without a stall
   function automatic logic [1:0] gc_next(input logic [1:0] gc);
      logic [1:0] nxt;
      case (gc)
         GC_00:   nxt = GC_01;
         GC_01:   nxt = GC_11;
         GC_11:   nxt = GC_10;
         GC_10:   nxt = GC_00;
         default: nxt = GC_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/gray_to_tp_sel_dec.sv
// Purely combinational decoder from a 2-bit Gray count to a one-hot
// test-pattern select. At most one output bit is ever high.
module gray_to_tp_sel_dec
   import gray_cnt_pkg::*;
(
   input  logic [1:0]          gc,
   output logic [TP_SEL_W-1:0] sel
);

   // Map each Gray state to its test-pattern select; unknown codes select nothing
   always_comb begin
      sel = SEL_NONE;
      case (gc)
         GC_01:   sel = SEL_TP0;
         GC_11:   sel = SEL_TP1;
         GC_10:   sel = SEL_TP2;
         GC_00:   sel = SEL_NONE;
         default: sel = SEL_NONE;
      endcase
   end

endmodule

// File: rtl/gray_cnt_2bit_init_val.sv
// 2-bit Gray-code counter with synchronous reset value, synchronous init
// load and a one-hot test-pattern select decoded from the count.
// Edge priority: in_ctr_Srst > in_ctr_init > in_ctr_en > hold.
// Optional macro GRAY_CNT_SEL_REG_EN registers out_sel_TP (1-cycle lag
// behind out_GC); without it out_sel_TP is a direct decode of out_GC.
module gray_cnt_2bit_init_val
   import gray_cnt_pkg::*;
#(
   parameter int unsigned TEST_SYND_NUM = 3
)(
   input  logic                     clk,
   input  logic                     in_ctr_Arst_n,
   input  logic                     in_ctr_Srst,
   input  logic                     in_ctr_en,
   input  logic                     in_ctr_init,
   input  logic [1:0]               in_val_Srst,
   input  logic [1:0]               in_val_init,
   output logic [1:0]               out_GC,
   output logic [TEST_SYND_NUM-1:0] out_sel_TP
);

   logic [1:0]          gc_r;
   logic [TP_SEL_W-1:0] dec_sel_s;

   // Counter register: async clear, then Srst load, init load, step, hold
   always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
      if (!in_ctr_Arst_n) begin
         gc_r <= GC_00;
      end else if (in_ctr_Srst) begin
         gc_r <= in_val_Srst;
      end else if (in_ctr_init) begin
         gc_r <= in_val_init;
      end else if (in_ctr_en) begin
         gc_r <= gc_next(gc_r);
      end else begin
         gc_r <= gc_r;
      end
   end

   // The count leaves the block straight from the register
   assign out_GC = gc_r;

   gray_to_tp_sel_dec u_dec (
      .gc  (gc_r),
      .sel (dec_sel_s)
   );

`ifdef GRAY_CNT_SEL_REG_EN
   logic [TP_SEL_W-1:0] sel_r;

   // Registered select: holds the decode of the previous cycle's count
   always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
      if (!in_ctr_Arst_n) begin
         sel_r <= SEL_NONE;
      end else if (in_ctr_Srst) begin
         sel_r <= SEL_NONE;
      end else begin
         sel_r <= dec_sel_s;
      end
   end

   assign out_sel_TP = sel_r;
`else
   // Combinational select, valid in the same cycle as out_GC
   assign out_sel_TP = dec_sel_s;
`endif

endmodule

// File: tb/tb_gray_cnt_2bit_init_val.sv
// Directed self-checking bench for gray_cnt_2bit_init_val (default build,
// combinational out_sel_TP). Expected values are written out by hand.
module tb_gray_cnt_2bit_init_val;

   logic       clk;
   logic       in_ctr_Arst_n;
   logic       in_ctr_Srst;
   logic       in_ctr_en;
   logic       in_ctr_init;
   logic [1:0] in_val_Srst;
   logic [1:0] in_val_init;
   logic [1:0] out_GC;
   logic [2:0] out_sel_TP;

   int tests;
   int fails;

   gray_cnt_2bit_init_val #(.TEST_SYND_NUM(3)) dut (
      .clk           (clk),
      .in_ctr_Arst_n (in_ctr_Arst_n),
      .in_ctr_Srst   (in_ctr_Srst),
      .in_ctr_en     (in_ctr_en),
      .in_ctr_init   (in_ctr_init),
      .in_val_Srst   (in_val_Srst),
      .in_val_init   (in_val_init),
      .out_GC        (out_GC),
      .out_sel_TP    (out_sel_TP)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] exp_gc, input logic [2:0] exp_sel);
      tests = tests + 1;
      assert (out_GC === exp_gc) else begin
         fails = fails + 1;
         $error("FAIL %s out_GC observed=%b expected=%b", tag, out_GC, exp_gc);
      end
      tests = tests + 1;
      assert (out_sel_TP === exp_sel) else begin
         fails = fails + 1;
         $error("FAIL %s out_sel_TP observed=%b expected=%b", tag, out_sel_TP, exp_sel);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      in_ctr_Arst_n = 1'b0;
      in_ctr_Srst   = 1'b0;
      in_ctr_en     = 1'b0;
      in_ctr_init   = 1'b0;
      in_val_Srst   = 2'b00;
      in_val_init   = 2'b01;

      // Reset state while async reset is held
      #3;
      check("reset", 2'b00, 3'b000);

      // Release between edges; first edge with all controls low holds 00
      #9;
      in_ctr_Arst_n = 1'b1;
      step();
      check("hold_after_rst", 2'b00, 3'b000);

      // Init pulse (with en high) loads 01, then en steps through the Gray order
      in_ctr_init = 1'b1;
      in_ctr_en   = 1'b1;
      in_val_init = 2'b01;
      step();
      check("init_01", 2'b01, 3'b001);
      in_ctr_init = 1'b0;
      step();
      check("cnt_11", 2'b11, 3'b010);
      step();
      check("cnt_10", 2'b10, 3'b100);
      step();
      check("wrap_00", 2'b00, 3'b000);
      step();
      check("cnt_01", 2'b01, 3'b001);
      step();
      check("cnt_11b", 2'b11, 3'b010);

      // Hold at 11 for three edges
      in_ctr_en = 1'b0;
      step();
      check("hold1", 2'b11, 3'b010);
      step();
      check("hold2", 2'b11, 3'b010);
      step();
      check("hold3", 2'b11, 3'b010);

      // Init with en low loads 10
      in_ctr_init = 1'b1;
      in_val_init = 2'b10;
      step();
      check("init_10", 2'b10, 3'b100);

      // Srst beats init and en
      in_ctr_Srst = 1'b1;
      in_ctr_en   = 1'b1;
      in_val_Srst = 2'b00;
      in_val_init = 2'b01;
      step();
      check("srst_prio", 2'b00, 3'b000);

      // Srst takes its value from the port
      in_val_Srst = 2'b11;
      step();
      check("srst_val_11", 2'b11, 3'b010);

      // Back to counting from 11
      in_ctr_Srst = 1'b0;
      in_ctr_init = 1'b0;
      step();
      check("cnt_after_srst", 2'b10, 3'b100);

      // Async reset mid-cycle clears immediately, without an edge
      #3;
      in_ctr_Arst_n = 1'b0;
      #1;
      check("arst_mid", 2'b00, 3'b000);
      step();
      check("arst_held_edge", 2'b00, 3'b000);

      // Release mid-cycle; first edge counts from 00
      #3;
      in_ctr_Arst_n = 1'b1;
      step();
      check("after_arst", 2'b01, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gray_cnt_2bit_init_val.md
GRAY_CNT_2BIT_INIT_VAL -- requirements
Module: gray_cnt_2bit_init_val

Interface
REQ-001 Parameter: TEST_SYND_NUM, default 3, width of one-hot test-pattern select output; only value 3 is supported.
REQ-002 Signal: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Signal: in_ctr_Arst_n  input  1  asynchronous, active-low reset.
REQ-004 Signal: in_ctr_Srst  input  1  synchronous reset, active-high.
REQ-005 Signal: in_ctr_en  input  1  count enable.
REQ-006 Signal: in_ctr_init  input  1  synchronous load of init value.
REQ-007 Signal: in_val_Srst  input  2  value loaded by in_ctr_Srst.
REQ-008 Signal: in_val_init  input  2  value loaded by in_ctr_init; system default tie-off is 2'b01.
REQ-009 Signal: out_GC  output  2  current Gray-code count.
REQ-010 Signal: out_sel_TP  output  TEST_SYND_NUM  one-hot test-pattern select decoded from out_GC.

Function
REQ-011 Counter SHALL step in 2-bit Gray order 00 -> 01 -> 11 -> 10 -> 00, changing exactly one bit per step.
REQ-012 From 10, the next step SHALL wrap to 00 with no stall.
REQ-013 Per rising edge, priority SHALL be: in_ctr_Srst (load in_val_Srst) > in_ctr_init (load in_val_init) > in_ctr_en (advance one step) > hold.
REQ-014 in_ctr_init SHALL load regardless of in_ctr_en.
REQ-015 Srst and init asserted together SHALL load in_val_Srst.
REQ-016 Counter SHALL hold when en, init and Srst are all low.
REQ-017 out_GC SHALL be the register value directly, with zero combinational logic on the output.
REQ-018 out_sel_TP SHALL decode from out_GC as follows: 01 -> 3'b001, 11 -> 3'b010, 10 -> 3'b100, 00 -> 3'b000.
REQ-019 out_sel_TP SHALL never have more than one bit high.
REQ-020 out_sel_TP SHALL be combinational from out_GC, valid in the same cycle as out_GC (0 cycles latency), unless REQ-026 applies.

Reset
REQ-021 in_ctr_Arst_n low SHALL immediately force the counter to 2'b00 and out_sel_TP to 3'b000, independent of clk.
REQ-022 Release of in_ctr_Arst_n SHALL take effect on the next rising edge; the first edge after release obeys REQ-013.
REQ-023 Async reset asserted mid-count SHALL discard the count; no state is retained.
REQ-024 Synchronous Srst SHALL use the in_val_Srst port value, not a constant.

Configuration
REQ-025 Macro GRAY_CNT_SEL_REG_EN selects whether out_sel_TP is registered.
REQ-026 With GRAY_CNT_SEL_REG_EN defined, out_sel_TP SHALL be registered and equal to decode(out_GC) of the previous cycle (1-cycle latency).
REQ-027 With GRAY_CNT_SEL_REG_EN defined, out_sel_TP SHALL reset to 3'b000 on async reset and on Srst.
REQ-028 With GRAY_CNT_SEL_REG_EN undefined, out_sel_TP SHALL behave per REQ-020.

Structure
REQ-029 Shared package gray_cnt_pkg SHALL hold the Gray-state constants (GC_00, GC_01, GC_11, GC_10), the next-state function, and the select encodings.
REQ-030 Decoder SHALL be one sub-module, gray_to_tp_sel_dec: 2-bit input, 3-bit one-hot output, purely combinational.
REQ-031 The sequential counter SHALL reside in the top module.

Verification
REQ-032 Assert in_ctr_Arst_n=0 mid-cycle -> out_GC=00 and out_sel_TP=000 immediately, before any clock edge.
REQ-033 Pulse init with in_val_init=01, then hold en=1 for 5 edges -> out_GC=01,11,10,00,01; out_sel_TP=001,010,100,000,001.
REQ-034 Srst=1 with init=1 and en=1, in_val_Srst=00, in_val_init=01 -> out_GC=00 after the edge.
REQ-035 en=0, init=0 at out_GC=11 for 3 edges -> out_GC stays 11, out_sel_TP stays 010.
REQ-036 init=1 with en=0, in_val_init=10 -> out_GC=10 and out_sel_TP=100 after one edge.
REQ-037 With GRAY_CNT_SEL_REG_EN defined, rerun REQ-033 -> out_sel_TP sequence lags out_GC by exactly one cycle.
